// File: rtl/us_timer_pkg.sv
// Shared types and defaults for the microsecond delay timer and its prescaler.
package us_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int US_CLKS_PER_US_DEF = 100;
  localparam int US_DUR_W_DEF       = 16;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CLKS_PER_US-1 while enabled and flags the wrap edge.
module us_tick_gen #(
  parameter int CLKS_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_US);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] cnt_q;

  // Tick is combinational so the owner acts on the same edge the counter wraps.
  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/us_delay_timer.sv
// Programmable microsecond delay/interval timer with one-shot and auto-reload modes.
module us_delay_timer
  import us_timer_pkg::*;
#(
  parameter int CLKS_PER_US = US_CLKS_PER_US_DEF,
  parameter int DUR_W       = US_DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DUR_W-1:0] duration,
  input  logic             periodic,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [DUR_W-1:0] remaining
);

  state_t           state_q;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] rem_q;
  logic             per_q;
  logic             busy_q;
  logic             done_q;
  logic             tick;
  logic             run;
  logic             last_tick;

  assign run       = (state_q == RUN);
  assign last_tick = tick && (rem_q == DUR_W'(1));

  // Prescaler runs only in RUN; abort or IDLE pins it to zero so a new start
  // always sees a full first microsecond.
  us_tick_gen #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (run),
    .clear  (!run || abort),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      rem_q   <= '0;
      per_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (duration != '0) begin
              state_q <= RUN;
              dur_q   <= duration;
              per_q   <= periodic;
              rem_q   <= duration;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
          end else if (last_tick) begin
            done_q <= 1'b1;
            if (per_q) begin
              rem_q <= dur_q;
            end else begin
              state_q <= IDLE;
              rem_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else if (tick) begin
            rem_q <= rem_q - DUR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          rem_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_us_delay_timer.sv
// Self-checking bench for us_delay_timer with CLKS_PER_US=4: per-cycle busy/remaining model plus a done-pulse scoreboard.
module tb_us_delay_timer;

  localparam int C = 4;
  localparam int W = 16;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         start    = 1'b0;
  logic [W-1:0] duration = '0;
  logic         periodic = 1'b0;
  logic         abort    = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] remaining;

  us_delay_timer #(.CLKS_PER_US(C), .DUR_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .duration  (duration),
    .periodic  (periodic),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each expected done is the edge number after which it is high.
  always @(negedge clk) begin
    if (rst && done) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL done_unexpected: pulse after edge %0d, none expected", cyc);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e != cyc) begin
          errors = errors + 1;
          $display("FAIL done_timing: pulse after edge %0d, required after edge %0d", cyc, exp_e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_start(input logic [W-1:0] d, input logic p, output int e0);
    @(negedge clk);
    start    = 1'b1;
    duration = d;
    periodic = p;
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [W-1:0] dur;
    int           lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int exp_busy;
    int exp_rem;

    vecs[0] = '{dur: 16'd3, lat: 12};
    vecs[1] = '{dur: 16'd1, lat: 4};
    vecs[2] = '{dur: 16'd0, lat: 0};
    vecs[3] = '{dur: 16'd2, lat: 8};
    vecs[4] = '{dur: 16'd6, lat: 24};

    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rem", int'(remaining), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // One-shot table, including zero duration
    foreach (vecs[i]) begin
      do_start(vecs[i].dur, 1'b0, e0);
      exp_q.push_back(e0 + vecs[i].lat);
      for (int n = 0; n <= vecs[i].lat + 2; n++) begin
        @(negedge clk);
        exp_busy = (n < vecs[i].lat) ? 1 : 0;
        exp_rem  = (n < vecs[i].lat) ? int'(vecs[i].dur) - n / C : 0;
        chk("os_busy", int'(busy), exp_busy);
        chk("os_rem", int'(remaining), exp_rem);
      end
      drain("os_done_missing");
    end

    // Periodic duration=2, periodic input cleared after latch, abort at E0+20
    do_start(16'd2, 1'b1, e0);
    exp_q.push_back(e0 + 8);
    exp_q.push_back(e0 + 16);
    for (int n = 0; n <= 29; n++) begin
      @(negedge clk);
      exp_busy = (n < 20) ? 1 : 0;
      exp_rem  = (n < 20) ? 2 - ((n / C) % 2) : 0;
      chk("per_busy", int'(busy), exp_busy);
      chk("per_rem", int'(remaining), exp_rem);
      if (n == 2)  periodic = 1'b0;
      if (n == 19) abort = 1'b1;
      if (n == 20) abort = 1'b0;
    end
    drain("per_done_missing");

    // start ignored while busy and on the expiry edge
    do_start(16'd5, 1'b0, e0);
    exp_q.push_back(e0 + 20);
    for (int n = 0; n <= 26; n++) begin
      @(negedge clk);
      exp_busy = (n < 20) ? 1 : 0;
      exp_rem  = (n < 20) ? 5 - n / C : 0;
      chk("ign_busy", int'(busy), exp_busy);
      chk("ign_rem", int'(remaining), exp_rem);
      if (n == 7 || n == 19) begin
        start    = 1'b1;
        duration = 16'd9;
      end
      if (n == 8 || n == 20) start = 1'b0;
    end
    drain("ign_done_missing");

    // abort on the final-tick edge of a one-shot
    do_start(16'd3, 1'b0, e0);
    for (int n = 0; n <= 17; n++) begin
      @(negedge clk);
      exp_busy = (n < 12) ? 1 : 0;
      exp_rem  = (n < 12) ? 3 - n / C : 0;
      chk("abt_busy", int'(busy), exp_busy);
      chk("abt_rem", int'(remaining), exp_rem);
      if (n == 11) abort = 1'b1;
      if (n == 12) abort = 1'b0;
    end

    // abort together with start in IDLE
    @(negedge clk);
    start    = 1'b1;
    abort    = 1'b1;
    duration = 16'd4;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("idle_abt_busy", int'(busy), 0);
    end

    // Async reset mid-count
    do_start(16'd5, 1'b0, e0);
    repeat (7) @(negedge clk);
    chk("mid_busy_pre", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_rem", int'(remaining), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;

    // Async reset while done is high
    do_start(16'd1, 1'b0, e0);
    exp_q.push_back(e0 + 4);
    repeat (5) @(negedge clk);
    chk("done_hi", int'(done), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_done_hi", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    drain("rst_done_missing");

    // Fresh start after reset release
    do_start(16'd1, 1'b0, e0);
    exp_q.push_back(e0 + C);
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      chk("post_busy", int'(busy), (n < C) ? 1 : 0);
      chk("post_rem", int'(remaining), (n < C) ? 1 : 0);
    end
    drain("post_done_missing");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
